// File: rtl/t08_spi_pkg.sv
// t08_spi_pkg: shared widths and FSM state type for the SPI transmitter
package t08_spi_pkg;
    localparam int BYTE_W = 8;
    localparam int CNT_W = 4;
    typedef enum logic [2:0] {IDLE, CMD, PWAIT, PARAM, DONE} state_e;
endpackage

// File: rtl/t08_spi_if.sv
// t08_spi_if: MMIO-side bus of the SPI transmitter
//   spi_data_i          write data ([7:0] byte, [11:8] param count on command writes)
//   spi_write_i         one-cycle write strobe
//   spi_read_i          reserved, no effect
//   spi_comm_enable_i   write is a command word
//   spi_param_enable_i  write is a parameter byte
//   spi_busy_o          transaction in progress
//   spi_overflow_o      sticky parameter-drop flag
interface t08_spi_if;
    logic [31:0] spi_data_i;
    logic        spi_write_i;
    logic        spi_read_i;
    logic        spi_comm_enable_i;
    logic        spi_param_enable_i;
    logic        spi_busy_o;
    logic        spi_overflow_o;
    modport master (
        output spi_data_i, spi_write_i, spi_read_i, spi_comm_enable_i, spi_param_enable_i,
        input  spi_busy_o, spi_overflow_o
    );
    modport slave (
        input  spi_data_i, spi_write_i, spi_read_i, spi_comm_enable_i, spi_param_enable_i,
        output spi_busy_o, spi_overflow_o
    );
endinterface

// File: rtl/t08_spi_param_fifo.sv
// t08_spi_param_fifo: synchronous byte FIFO buffering SPI parameter bytes
//   push_i/din_i  write a byte (accepted when not full, or when full and popping)
//   pop_i/dout_o  dout_o shows the head; pop_i removes it (ignored when empty)
//   full_o, empty_o, count_o  occupancy status
module t08_spi_param_fifo
    import t08_spi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [BYTE_W-1:0]        din_i,
    output logic [BYTE_W-1:0]        dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, rd_q;
    logic [AW:0]       cnt_q;
    logic              do_push, do_pop;
    assign do_pop  = pop_i & ~empty_o;
    // a pop frees the slot in the same cycle, so a full FIFO still accepts
    assign do_push = push_i & (~full_o | do_pop);
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= do_push ? wr_q + 1'b1 : wr_q;
            rd_q  <= do_pop ? rd_q + 1'b1 : rd_q;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/t08_spi_tx.sv
// t08_spi_tx: serialises a command byte and its parameter bytes as SPI mode 0, MSB first
//   clk, rst        system clock, synchronous active-high reset
//   bus             MMIO-side t08_spi_if slave (writes in, busy/overflow out)
//   spi_sclk_o      serial clock, idle low
//   spi_mosi_o      serial data
//   spi_cs_n_o      chip select, low for the whole command+parameter frame
//   spi_dc_o        0 = command byte, 1 = parameter byte
module t08_spi_tx
    import t08_spi_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    t08_spi_if.slave  bus,
    output logic      spi_sclk_o,
    output logic      spi_mosi_o,
    output logic      spi_cs_n_o,
    output logic      spi_dc_o
);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    state_e             state_q;
    logic [CNT_W-1:0]   rem_q;
    logic [BYTE_W-1:0]  sh_q;
    logic [DIV_W-1:0]   div_q;
    logic [2:0]         bit_q;
    logic               busy_q, ovf_q, sclk_q, mosi_q, cs_n_q, dc_q;
    logic               cmd_wr, prm_wr, pop_d, tick, fin;
    logic [BYTE_W-1:0]  fifo_dout;
    logic               fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic               unused_ok;

    assign cmd_wr = bus.spi_write_i & bus.spi_comm_enable_i;
    assign prm_wr = bus.spi_write_i & bus.spi_param_enable_i & ~bus.spi_comm_enable_i;
    assign pop_d  = (state_q == PWAIT) & ~fifo_empty;
    assign tick   = div_q == DIV_W'(CLK_DIV - 1);
    // the byte now finishing is the last one of the frame
    assign fin    = (state_q == CMD) ? (rem_q == '0) : (rem_q == CNT_W'(1));
    assign unused_ok = ^{bus.spi_read_i, bus.spi_data_i[31:12], fifo_count};

    t08_spi_param_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (prm_wr),
        .pop_i   (pop_d),
        .din_i   (bus.spi_data_i[BYTE_W-1:0]),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            sh_q    <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            dc_q    <= 1'b0;
        end else begin
            if (prm_wr & fifo_full & ~pop_d) ovf_q <= 1'b1;
            case (state_q)
                IDLE: if (cmd_wr) begin
                    state_q <= CMD;
                    sh_q    <= bus.spi_data_i[7:0];
                    rem_q   <= bus.spi_data_i[11:8];
                    mosi_q  <= bus.spi_data_i[7];
                    cs_n_q  <= 1'b0;
                    busy_q  <= 1'b1;
                    dc_q    <= 1'b0;
                    div_q   <= '0;
                    bit_q   <= '0;
                    sclk_q  <= 1'b0;
                end
                CMD, PARAM: begin
                    div_q <= tick ? '0 : div_q + 1'b1;
                    if (tick) begin
                        sclk_q <= ~sclk_q;
                        if (sclk_q && bit_q == 3'd7) begin
                            rem_q   <= (state_q == PARAM) ? rem_q - 1'b1 : rem_q;
                            state_q <= fin ? DONE : PWAIT;
                            cs_n_q  <= fin;
                        end else if (sclk_q) begin
                            // falling transition: advance to the next bit
                            bit_q  <= bit_q + 1'b1;
                            sh_q   <= {sh_q[BYTE_W-2:0], 1'b0};
                            mosi_q <= sh_q[BYTE_W-2];
                        end
                    end
                end
                PWAIT: if (!fifo_empty) begin
                    state_q <= PARAM;
                    sh_q    <= fifo_dout;
                    mosi_q  <= fifo_dout[BYTE_W-1];
                    dc_q    <= 1'b1;
                    div_q   <= '0;
                    bit_q   <= '0;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    dc_q    <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.spi_busy_o     = busy_q;
    assign bus.spi_overflow_o = ovf_q;
    assign spi_sclk_o = sclk_q;
    assign spi_mosi_o = mosi_q;
    assign spi_cs_n_o = cs_n_q;
    assign spi_dc_o   = dc_q;
endmodule

// File: doc/t08_spi_tx.md
Name: t08_spi_tx

Overview:
- SPI transmitter at the display end of the MMIO→SPI path.
- Accepts a command-word write (command byte plus parameter count) and parameter writes from the MMIO block, and buffers parameters in a small FIFO.
- Serialises the command byte (DC=0) followed by the announced number of parameter bytes (DC=1) as SPI mode 0, MSB first, framed by one CS low period.
- Drives `spi_busy_o`, which gates further command writes upstream.

Parameters:
- CLK_DIV, 2, clk cycles per SCLK half-period; legal range ≥1.
- FIFO_DEPTH, 4, parameter FIFO entries; must be a power of 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- spi_data_i  in  32  write data from MMIO
- spi_write_i  in  1  write strobe, one cycle
- spi_read_i  in  1  reserved; no effect
- spi_comm_enable_i  in  1  qualifies the write as a command word: [7:0]=command, [11:8]=param count
- spi_param_enable_i  in  1  qualifies the write as a parameter: [7:0] is sent, [31:8] is ignored
- spi_busy_o  out  1  transaction in progress
- spi_overflow_o  out  1  sticky: a parameter was dropped because the FIFO was full
- spi_sclk_o  out  1  serial clock, idle low
- spi_mosi_o  out  1  serial data
- spi_cs_n_o  out  1  chip select, active low
- spi_dc_o  out  1  0 = command byte, 1 = parameter byte

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, FIFO flushed, remaining=0.
  - busy=0, overflow=0, sclk=0, mosi=0, cs_n=1, dc=0.
  - Reset mid-transfer aborts the transfer immediately: CS rises on the next edge and no partial-byte completion occurs.
- All outputs are registered.
- Command accept:
  - Condition: spi_write_i & spi_comm_enable_i & state==IDLE.
  - On accept at edge N: cmd latched, remaining=[11:8].
  - From N+1: busy=1, cs_n=0, dc=0, mosi=cmd[7].
  - A command write when not IDLE is ignored.
  - If comm_enable and param_enable are both high, the write is treated as a command; the param_enable strobe is ignored.
- Parameter push:
  - Condition: spi_write_i & spi_param_enable_i & !spi_comm_enable_i.
  - Pushes [7:0] in any state, including IDLE, so parameters can be preloaded.
  - If the FIFO is full and no pop occurs that cycle: the byte is dropped and overflow is set (cleared only by rst).
  - Push and pop in the same cycle: both succeed and the count is unchanged, also when the FIFO is full.
- Byte shifter:
  - Each bit: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - mosi changes only on the sclk falling transition, or at byte start.
  - Byte = 16*CLK_DIV cycles.
  - After the 8th high phase, sclk returns low and the byte is done.
- FSM:
  - IDLE: accept → CMD.
  - CMD: shift cmd with dc=0. At byte done: remaining==0 → DONE; else → PWAIT.
  - PWAIT: cs_n stays 0, sclk low. FIFO non-empty → pop the head, load the shifter, dc=1, go to PARAM. Waits indefinitely; there is no timeout.
  - PARAM: shift the byte. At byte done, remaining−1: result 0 → DONE; else → PWAIT.
  - Pop-to-PARAM handoff: when the FIFO is already non-empty at byte done, the next byte begins on the very next cycle via a single PWAIT cycle.
  - DONE: one cycle with cs_n=1 and busy still 1 → IDLE with busy=0.
  - Leftover FIFO entries beyond the announced count remain queued for the next command.
- Total transaction length with the FIFO pre-filled:
  - 16*CLK_DIV*(1+count) shift cycles
  - + count PWAIT cycles
  - + 1 DONE cycle.
- Counter width is 4 bits; count 15 is legal. A count exceeding the FIFO depth is legal because the FIFO refills during the transfer.

Decomposition:
- Package `t08_spi_pkg`: state enum {IDLE, CMD, PWAIT, PARAM, DONE}, BYTE_W=8, CNT_W=4.
- Sub-module `t08_spi_param_fifo`: synchronous FIFO, 8-bit wide, FIFO_DEPTH entries; ports push, pop, din, dout, full, empty, count; same clk/rst.
- The top level holds the FSM, the bit/divider counters and the shift register.

Test Plan:
1. Reset with CLK_DIV=2, then command write 32'h0000_002C (count 0).
   - Required: cs_n low for exactly 32 cycles; mosi samples on the sclk rises = 0x2C MSB first with dc=0.
   - Then one DONE cycle, then busy=0.
2. Preload params 0x11, 0x22, then command 32'h0000_022A.
   - Required: bytes 0x2A (dc=0), 0x11 (dc=1), 0x22 (dc=1).
   - busy high for 32*3+2+1=99 cycles.
3. Command 32'h0000_0136 with an empty FIFO; push param 0x48 100 cycles later.
   - Required: cs_n held low and sclk idle throughout the wait.
   - 0x48 is sent beginning 2 cycles after the push; then DONE.
4. Push 5 params into an empty FIFO while IDLE.
   - Required: 5th byte dropped and overflow=1.
   - A following command with count 4 sends the first 4 bytes in order.
5. Command write issued while busy, plus a simultaneous comm_enable and param_enable write.
   - Required: the in-flight transfer is unaffected and the FIFO count is unchanged.
6. rst asserted mid-PARAM.
   - Required: next edge gives cs_n=1, sclk=0, busy=0, FIFO empty, overflow=0.
   - A new command afterwards transmits normally.
